// File: rtl/dbg_step_sequencer_pkg.sv
// Shared constants for the UART debug step sequencer: command bytes, ack bytes,
// FSM state encodings and reset polarity.
package dbg_step_sequencer_pkg;

  // Command bytes received from the UART
  localparam logic [7:0] DBG_CMD_RESET = 8'h72;  // 'r'
  localparam logic [7:0] DBG_CMD_STEP  = 8'h70;  // 'p'
  localparam logic [7:0] DBG_CMD_NSTEP = 8'h73;  // 's'
  localparam logic [7:0] DBG_CMD_RUN   = 8'h67;  // 'g'
  localparam logic [7:0] DBG_CMD_HALT  = 8'h68;  // 'h'

  // Ack bytes returned to the UART
  localparam logic [7:0] DBG_ACK_OK    = 8'h6B;  // 'k'
  localparam logic [7:0] DBG_ACK_ERR   = 8'h3F;  // '?'

  // FSM state encodings
  localparam logic [2:0] DBG_ST_IDLE   = 3'd0;
  localparam logic [2:0] DBG_ST_ARG    = 3'd1;
  localparam logic [2:0] DBG_ST_RST    = 3'd2;
  localparam logic [2:0] DBG_ST_STEP   = 3'd3;
  localparam logic [2:0] DBG_ST_RUN    = 3'd4;
  localparam logic [2:0] DBG_ST_ACK    = 3'd5;

  // Reset polarity of the system reset input
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  // States in which the core is actively driven (clocked or held in reset)
  function automatic logic st_is_busy(input logic [2:0] st);
    return (st == DBG_ST_RST) || (st == DBG_ST_STEP) || (st == DBG_ST_RUN);
  endfunction

endpackage

// File: rtl/dbg_cycle_timer.sv
// Loadable down-counter with a terminal-count flag. The flag is high during the
// last cycle of an interval, so loading L yields an interval of exactly L cycles.
module dbg_cycle_timer
  import dbg_step_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; otherwise count down and stop at zero (no wrap)
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CntOne;
    end
  end

  assign o_tc = (r_cnt == CntOne);

endmodule

// File: rtl/dbg_step_sequencer.sv
// UART-driven debug sequencer: decodes command bytes and drives the core
// clock-enable and soft reset (run, halt, single-step, N-step, reset).
// Optional feature macro: DBG_ACK_EN -- when defined, every completed command
// returns an ack byte ('k' ok / '?' error) to the UART transmitter.
module dbg_step_sequencer
  import dbg_step_sequencer_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25000000,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       cpu_clk_en,
  output logic       cpu_resetn,
  output logic       halted,
  output logic       busy,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  localparam logic [CNT_W-1:0] StepLoad = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] RstLoad  = CNT_W'(RST_CYCLES);

  logic [2:0]       r_state;
  logic [2:0]       w_state_d;
  logic             r_gap;       // STEP sub-phase: the single low cycle between steps
  logic             w_gap_d;
  logic [7:0]       r_steps;
  logic [7:0]       w_steps_d;
  logic             w_enter;
  logic             w_done;
  logic             w_done_ok;
  logic             w_is_rst;
  logic             w_is_halt;
  logic             w_tmr_tc;
  logic [CNT_W-1:0] w_tmr_value;

  logic r_cpu_clk_en;
  logic r_cpu_resetn;
  logic r_halted;
  logic r_busy;

  assign w_is_rst  = rx_done && (rx_data == DBG_CMD_RESET);
  assign w_is_halt = rx_done && (rx_data == DBG_CMD_HALT);

`ifdef DBG_ACK_EN
  logic       r_ack_ok;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  logic       w_tx_start_d;
`endif

  // Next-state decode; 'r' and 'h' take precedence over interval completion
  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap;
    w_steps_d = r_steps;
    w_enter   = 1'b0;
    w_done    = 1'b0;
    w_done_ok = 1'b1;
`ifdef DBG_ACK_EN
    w_tx_start_d = 1'b0;
`endif
    case (r_state)
      DBG_ST_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            DBG_CMD_RESET: w_state_d = DBG_ST_RST;
            DBG_CMD_STEP: begin
              w_state_d = DBG_ST_STEP;
              w_steps_d = 8'd1;
            end
            DBG_CMD_NSTEP: w_state_d = DBG_ST_ARG;
            DBG_CMD_RUN:   w_state_d = DBG_ST_RUN;
            DBG_CMD_HALT:  w_done    = 1'b1;
            default: begin
              w_done    = 1'b1;
              w_done_ok = 1'b0;
            end
          endcase
        end
      end
      DBG_ST_ARG: begin
        // Any byte here is the step count, including 'r'
        if (rx_done) begin
          if (rx_data == 8'd0) begin
            w_done    = 1'b1;
            w_done_ok = 1'b0;
          end else begin
            w_state_d = DBG_ST_STEP;
            w_steps_d = rx_data;
          end
        end
      end
      DBG_ST_STEP: begin
        if (w_is_rst) begin
          w_state_d = DBG_ST_RST;
        end else if (w_is_halt) begin
          w_done = 1'b1;
        end else if (!r_gap) begin
          if (w_tmr_tc) w_gap_d = 1'b1;
        end else if (r_steps == 8'd1) begin
          w_steps_d = 8'd0;
          w_done    = 1'b1;
        end else begin
          // Start the next step: reload the timer for a fresh high window
          w_steps_d = r_steps - 8'd1;
          w_gap_d   = 1'b0;
          w_enter   = 1'b1;
        end
      end
      DBG_ST_RUN: begin
        if (w_is_rst) begin
          w_state_d = DBG_ST_RST;
        end else if (w_is_halt) begin
          w_done = 1'b1;
        end
      end
      DBG_ST_RST: begin
        if (w_is_rst) begin
          w_enter = 1'b1;  // restart the reset interval
        end else if (w_tmr_tc) begin
          w_done = 1'b1;
        end
      end
`ifdef DBG_ACK_EN
      DBG_ST_ACK: begin
        if (w_is_rst) begin
          w_state_d = DBG_ST_RST;
        end else if (!tx_busy) begin
          w_tx_start_d = 1'b1;
          w_state_d    = DBG_ST_IDLE;
        end
      end
`endif
      default: w_state_d = DBG_ST_IDLE;
    endcase

    if (w_done) begin
`ifdef DBG_ACK_EN
      w_state_d = DBG_ST_ACK;
`else
      w_state_d = DBG_ST_IDLE;
`endif
    end
    if (w_state_d != r_state) w_enter = 1'b1;
    if (w_state_d != DBG_ST_STEP) w_gap_d = 1'b0;
  end

  // Interval to load on state entry; other states clear the counter
  always_comb begin
    w_tmr_value = '0;
    if (w_state_d == DBG_ST_STEP) begin
      w_tmr_value = StepLoad;
    end else if (w_state_d == DBG_ST_RST) begin
      w_tmr_value = RstLoad;
    end
  end

  dbg_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_enter),
    .i_value (w_tmr_value),
    .o_tc    (w_tmr_tc)
  );

  // FSM state, step counter and registered outputs derived from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_state      <= DBG_ST_IDLE;
      r_gap        <= 1'b0;
      r_steps      <= 8'd0;
      r_cpu_clk_en <= 1'b0;
      r_cpu_resetn <= 1'b1;
      r_halted     <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_gap        <= w_gap_d;
      r_steps      <= w_steps_d;
      r_cpu_clk_en <= (w_state_d == DBG_ST_RUN) || ((w_state_d == DBG_ST_STEP) && !w_gap_d);
      r_cpu_resetn <= (w_state_d != DBG_ST_RST);
      r_halted     <= !st_is_busy(w_state_d);
      r_busy       <= st_is_busy(w_state_d);
    end
  end

`ifdef DBG_ACK_EN
  // Ack status latch and one-cycle transmit request
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_ack_ok   <= 1'b1;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      if (w_done) r_ack_ok <= w_done_ok;
      r_tx_start <= w_tx_start_d;
      if (w_tx_start_d) r_tx_data <= r_ack_ok ? DBG_ACK_OK : DBG_ACK_ERR;
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
`else
  logic w_unused_ack;
  assign w_unused_ack = ^{tx_busy, w_done_ok};
  assign tx_start     = 1'b0;
  assign tx_data      = 8'h00;
`endif

  assign cpu_clk_en = r_cpu_clk_en;
  assign cpu_resetn = r_cpu_resetn;
  assign halted     = r_halted;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dbg_step_sequencer.sv
// Directed bench for dbg_step_sequencer (STEP_CYCLES=4, RST_CYCLES=3).
// Ack expectations follow whether DBG_ACK_EN is defined for this build.
module tb_dbg_step_sequencer;

`ifdef DBG_ACK_EN
  localparam int ACKS = 1;
`else
  localparam int ACKS = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       cpu_clk_en;
  logic       cpu_resetn;
  logic       halted;
  logic       busy;
  logic       tx_start;
  logic [7:0] tx_data;

  int checks = 0;
  int failures = 0;

  logic [63:0] rec_en;
  logic [63:0] rec_rst;
  int          pulses;
  logic [7:0]  last_data;

  always #5 clk = ~clk;

  dbg_step_sequencer #(
    .STEP_CYCLES (4),
    .RST_CYCLES  (3),
    .CNT_W       (25)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .cpu_clk_en (cpu_clk_en),
    .cpu_resetn (cpu_resetn),
    .halted     (halted),
    .busy       (busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data)
  );

  // One-cycle rx_done strobe; returns just after the edge that samples it
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  // Sample n cycles at the falling edge: enable, reset-active, ack pulses
  task automatic record(input int n);
    rec_en = '0;
    rec_rst = '0;
    pulses = 0;
    last_data = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec_en[i]  = cpu_clk_en;
      rec_rst[i] = ~cpu_resetn;
      if (tx_start) begin
        pulses++;
        last_data = tx_data;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_clk_en, cpu_resetn, halted, busy, tx_start, tx_data} !== {5'b01100, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got=%b_%h exp=01100_00",
               {cpu_clk_en, cpu_resetn, halted, busy, tx_start}, tx_data);
    end
    resetn = 1'b1;
    record(4);
    checks++;
    if (rec_en[3:0] !== 4'h0 || rec_rst[3:0] !== 4'h0 || pulses != 0) begin
      failures++;
      $display("FAIL idle_quiet got en=%h rst=%h pulses=%0d exp=0/0/0",
               rec_en[3:0], rec_rst[3:0], pulses);
    end
  endtask

  task automatic test_single_step;
    send_byte(8'h70);
    checks++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL step_busy got busy=%b halted=%b exp=1/0", busy, halted);
    end
    record(12);
    checks++;
    if (rec_en[11:0] !== 12'h00F) begin
      failures++;
      $display("FAIL step_window got=%h exp=00f", rec_en[11:0]);
    end
    checks++;
    if (pulses != ACKS) begin
      failures++;
      $display("FAIL step_ack_count got=%0d exp=%0d", pulses, ACKS);
    end
`ifdef DBG_ACK_EN
    checks++;
    if (last_data !== 8'h6B) begin
      failures++;
      $display("FAIL step_ack_data got=%h exp=6b", last_data);
    end
`endif
  endtask

  task automatic test_n_step;
    send_byte(8'h73);
    checks++;
    if (halted !== 1'b1 || cpu_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL arg_wait got halted=%b en=%b exp=1/0", halted, cpu_clk_en);
    end
    send_byte(8'h03);
    record(24);
    checks++;
    if (rec_en[23:0] !== 24'h003DEF) begin
      failures++;
      $display("FAIL nstep_windows got=%h exp=003def", rec_en[23:0]);
    end
    checks++;
    if (pulses != ACKS) begin
      failures++;
      $display("FAIL nstep_ack_count got=%0d exp=%0d", pulses, ACKS);
    end
`ifdef DBG_ACK_EN
    checks++;
    if (last_data !== 8'h6B) begin
      failures++;
      $display("FAIL nstep_ack_data got=%h exp=6b", last_data);
    end
`endif
  endtask

  task automatic test_run_halt;
    send_byte(8'h67);
    record(20);
    checks++;
    if (rec_en[19:0] !== 20'hFFFFF) begin
      failures++;
      $display("FAIL run_enable got=%h exp=fffff", rec_en[19:0]);
    end
    send_byte(8'h70);  // dropped while running
    checks++;
    if (cpu_clk_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL run_drop got en=%b busy=%b exp=1/1", cpu_clk_en, busy);
    end
    send_byte(8'h68);
    checks++;
    if (cpu_clk_en !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL halt_stop got en=%b halted=%b busy=%b exp=0/1/0",
               cpu_clk_en, halted, busy);
    end
    record(6);
    checks++;
    if (pulses != ACKS || rec_en[5:0] !== 6'h00) begin
      failures++;
      $display("FAIL halt_ack got pulses=%0d en=%h exp=%0d/00", pulses, rec_en[5:0], ACKS);
    end
  endtask

  task automatic test_run_reset_busy;
    send_byte(8'h67);
    record(3);
    checks++;
    if (rec_en[2:0] !== 3'b111) begin
      failures++;
      $display("FAIL run2_enable got=%b exp=111", rec_en[2:0]);
    end
    tx_busy = 1'b1;
    send_byte(8'h72);
    record(5);
    checks++;
    if (rec_rst[4:0] !== 5'b00111 || rec_en[4:0] !== 5'b00000) begin
      failures++;
      $display("FAIL rst_pulse got rst=%b en=%b exp=00111/00000", rec_rst[4:0], rec_en[4:0]);
    end
    checks++;
    if (pulses != 0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL ack_held got pulses=%0d halted=%b exp=0/1", pulses, halted);
    end
    tx_busy = 1'b0;
    record(6);
    checks++;
    if (pulses != ACKS) begin
      failures++;
      $display("FAIL ack_release got=%0d exp=%0d", pulses, ACKS);
    end
  endtask

  task automatic test_reset_restart;
    send_byte(8'h72);
    checks++;
    if (cpu_resetn !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_start got resetn=%b busy=%b exp=0/1", cpu_resetn, busy);
    end
    send_byte(8'h72);
    record(8);
    checks++;
    if (rec_rst[7:0] !== 8'h07) begin
      failures++;
      $display("FAIL rst_restart got=%h exp=07", rec_rst[7:0]);
    end
    checks++;
    if (pulses != ACKS) begin
      failures++;
      $display("FAIL rst_ack got=%0d exp=%0d", pulses, ACKS);
    end
  endtask

  task automatic test_arg_r_then_halt;
    send_byte(8'h73);
    send_byte(8'h72);  // step count 114, not a reset
    record(8);
    checks++;
    if (rec_en[7:0] !== 8'hEF || rec_rst[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL arg_r_steps got en=%h rst=%h exp=ef/00", rec_en[7:0], rec_rst[7:0]);
    end
    send_byte(8'h68);
    checks++;
    if (cpu_clk_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL step_halt got en=%b busy=%b exp=0/0", cpu_clk_en, busy);
    end
    record(6);
    checks++;
    if (pulses != ACKS || rec_en[5:0] !== 6'h00) begin
      failures++;
      $display("FAIL step_halt_ack got pulses=%0d en=%h exp=%0d/00", pulses, rec_en[5:0], ACKS);
    end
  endtask

  task automatic test_errors;
    send_byte(8'h73);
    send_byte(8'h00);
    record(10);
    checks++;
    if (rec_en[9:0] !== 10'h000 || pulses != ACKS) begin
      failures++;
      $display("FAIL zero_n got en=%h pulses=%0d exp=000/%0d", rec_en[9:0], pulses, ACKS);
    end
`ifdef DBG_ACK_EN
    checks++;
    if (last_data !== 8'h3F) begin
      failures++;
      $display("FAIL zero_n_data got=%h exp=3f", last_data);
    end
`endif
    send_byte(8'h78);
    record(6);
    checks++;
    if (rec_en[5:0] !== 6'h00 || pulses != ACKS) begin
      failures++;
      $display("FAIL bad_cmd got en=%h pulses=%0d exp=00/%0d", rec_en[5:0], pulses, ACKS);
    end
`ifdef DBG_ACK_EN
    checks++;
    if (last_data !== 8'h3F) begin
      failures++;
      $display("FAIL bad_cmd_data got=%h exp=3f", last_data);
    end
`endif
  endtask

  task automatic test_async_reset;
    send_byte(8'h70);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_clk_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_step got=%b exp=1", cpu_clk_en);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({cpu_clk_en, cpu_resetn, halted, busy, tx_start, tx_data} !== {5'b01100, 8'h00}) begin
      failures++;
      $display("FAIL async_reset got=%b_%h exp=01100_00",
               {cpu_clk_en, cpu_resetn, halted, busy, tx_start}, tx_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    record(10);
    checks++;
    if (rec_en[9:0] !== 10'h000 || pulses != 0) begin
      failures++;
      $display("FAIL post_reset_quiet got en=%h pulses=%0d exp=000/0", rec_en[9:0], pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_n_step();
    test_run_halt();
    test_run_reset_busy();
    test_reset_restart();
    test_arg_r_then_halt();
    test_errors();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
